// File: rtl/axi4lite_reg_slave_pkg.sv
// Shared constants, FSM state types and the write-request payload for the
// AXI4-Lite register slave.
package axi4lite_reg_slave_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned OFFS_W = 12;

  localparam int unsigned NUM_CTL_REGS  = 6;
  localparam int unsigned REG_CTL_STATE = 5;
  localparam int unsigned REG_STATUS0   = 6;
  localparam int unsigned REG_STATUS1   = 7;

  localparam int unsigned OFFS_STATUS0 = 32'h18;
  localparam int unsigned OFFS_STATUS1 = 32'h1C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_ACCEPT, W_RESP} wr_state_e;
  typedef enum logic {R_ACCEPT, R_RESP} rd_state_e;

  typedef struct packed {
    logic [OFFS_W-1:0] offs;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Word index of a byte offset; bits [1:0] are dropped.
  function automatic logic [IDX_W-1:0] offs_to_idx(input logic [OFFS_W-1:0] offs);
    return IDX_W'(offs >> 2);
  endfunction

endpackage

// File: rtl/axi4lite_strobe_merge.sv
// Byte-lane merge: lanes with strobe set take the new data, others keep old.
module axi4lite_strobe_merge
  import axi4lite_reg_slave_pkg::*;
(
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] new_i,
  input  logic [STRB_W-1:0] strb_i,
  output logic [DATA_W-1:0] merged_c
);

  always_comb begin
    merged_c = old_i;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb_i[b]) merged_c[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave with six R/W control registers and two read-only status
// registers; independent write and read channel FSMs.
module axi4lite_reg_slave
  import axi4lite_reg_slave_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter logic [31:0] RESET_CTL_STATE = 32'h0
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  input  logic [AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic [AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  input  logic [2:0]                       S_AXI_ARPROT,
  output logic [AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_CTL_REGS*DATA_W-1:0]   ctl_reg,
  input  logic [DATA_W-1:0]                status0,
  input  logic [DATA_W-1:0]                status1,
  output logic [NUM_CTL_REGS-1:0]          reg_wr_pulse
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic b_valid_q, b_valid_d;
  logic [1:0] b_resp_q, b_resp_d;
  wr_req_t req_q, req_d, cur_req;
  logic [NUM_CTL_REGS-1:0][DATA_W-1:0] ctl_q, ctl_d;
  logic [NUM_CTL_REGS-1:0] pulse_q, pulse_d;
  logic ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [1:0] r_resp_q, r_resp_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;

  logic aw_hs, w_hs, ar_hs, wr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [OFFS_W-1:0] rd_offs;
  logic [DATA_W-1:0] merged;
  logic unused_inputs;

  assign unused_inputs = ^{S_AXI_AWADDR[AXI_ADDR_WIDTH-1:OFFS_W],
                           S_AXI_ARADDR[AXI_ADDR_WIDTH-1:OFFS_W],
                           S_AXI_AWPROT, S_AXI_ARPROT};

  assign aw_hs = S_AXI_AWVALID & aw_ready_q;
  assign w_hs  = S_AXI_WVALID & w_ready_q;
  assign ar_hs = S_AXI_ARVALID & ar_ready_q;

  // Request as seen in the commit cycle: live bus values win over latched ones.
  always_comb begin
    cur_req      = req_q;
    if (aw_hs) cur_req.offs = S_AXI_AWADDR[OFFS_W-1:0];
    if (w_hs) begin
      cur_req.data = DATA_W'(S_AXI_WDATA);
      cur_req.strb = STRB_W'(S_AXI_WSTRB);
    end
  end

  assign wr_idx = offs_to_idx(cur_req.offs);
  assign wr_ok  = cur_req.offs < OFFS_W'(OFFS_STATUS0);

  axi4lite_strobe_merge u_merge (
    .old_i   (ctl_q[wr_idx]),
    .new_i   (cur_req.data),
    .strb_i  (cur_req.strb),
    .merged_c(merged)
  );

  // Write channel next state.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    req_d      = req_q;
    ctl_d      = ctl_q;
    pulse_d    = '0;
    case (wr_state_q)
      W_ACCEPT: begin
        req_d = cur_req;
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          b_valid_d  = 1'b1;
          wr_state_d = W_RESP;
          if (wr_ok) begin
            ctl_d[wr_idx]   = merged;
            pulse_d[wr_idx] = 1'b1;
            b_resp_d        = RESP_OKAY;
          end else begin
            b_resp_d = RESP_SLVERR;
          end
        end else begin
          aw_done_d  = aw_done_q | aw_hs;
          w_done_d   = w_done_q | w_hs;
          aw_ready_d = ~(aw_done_q | aw_hs);
          w_ready_d  = ~(w_done_q | w_hs);
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          wr_state_d = W_ACCEPT;
        end
      end
    endcase
  end

  assign rd_offs = S_AXI_ARADDR[OFFS_W-1:0];
  assign rd_idx  = offs_to_idx(rd_offs);
  assign rd_ok   = rd_offs < OFFS_W'(OFFS_STATUS1 + 4);

  // Read channel next state; data sampled from pre-update register values.
  always_comb begin
    rd_state_d = rd_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    case (rd_state_q)
      R_ACCEPT: begin
        ar_ready_d = 1'b1;
        if (ar_hs) begin
          ar_ready_d = 1'b0;
          r_valid_d  = 1'b1;
          rd_state_d = R_RESP;
          if (rd_ok) begin
            r_resp_d = RESP_OKAY;
            case (rd_idx)
              IDX_W'(REG_STATUS0): r_data_d = status0;
              IDX_W'(REG_STATUS1): r_data_d = status1;
              default:             r_data_d = ctl_q[rd_idx];
            endcase
          end else begin
            r_resp_d = RESP_SLVERR;
            r_data_d = '0;
          end
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          rd_state_d = R_ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_ACCEPT;
      rd_state_q <= R_ACCEPT;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
      req_q      <= '0;
      ctl_q      <= '0;
      ctl_q[REG_CTL_STATE] <= RESET_CTL_STATE;
      pulse_q    <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= '0;
      r_data_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      req_q      <= req_d;
      ctl_q      <= ctl_d;
      pulse_q    <= pulse_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = w_ready_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = b_resp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RRESP   = r_resp_q;
  assign S_AXI_RDATA   = AXI_DATA_WIDTH'(r_data_q);
  assign ctl_reg       = ctl_q;
  assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: vector table of single writes with
// readback, plus hand sequences for ordering, backpressure and reset.
module tb_axi4lite_reg_slave;

  localparam logic [31:0] RST_CTL = 32'hA5A5_0003;
  localparam logic [31:0] ST0     = 32'hCAFE_0001;
  localparam logic [31:0] ST1     = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic [3:0]  WSTRB = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [191:0] ctl_reg;
  logic [5:0]  reg_wr_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi4lite_reg_slave #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .RESET_CTL_STATE(RST_CTL)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY), .S_AXI_AWPROT(3'b000),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY), .S_AXI_ARPROT(3'b000),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .ctl_reg(ctl_reg), .status0(ST0), .status1(ST1), .reg_wr_pulse(reg_wr_pulse)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [5:0]  pulse;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] reg_of(input int n);
    return ctl_reg[32*n +: 32];
  endfunction

  task automatic wait_wr_ready();
    int n = 0;
    while (!(AWREADY && WREADY) && n < 20) begin step(); n++; end
    chk("wr_ready_wait", {AWREADY, WREADY}, 2'b11);
  endtask

  task automatic wait_rd_ready();
    int n = 0;
    while (!ARREADY && n < 20) begin step(); n++; end
    chk("rd_ready_wait", ARREADY, 1'b1);
  endtask

  // Leaves the bench in cycle C+1 of an AW+W same-cycle write.
  task automatic wr_same(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_wr_ready();
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic b_done();
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    wait_rd_ready();
    ARADDR = a; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    chk("rvalid_latency", RVALID, 1'b1);
    d = RDATA; r = RRESP;
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    chk("r_handshake", RVALID, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    vecs[0] = '{32'h14,  32'h0000_0042, 4'hF, 2'b00, 6'b100000, 32'h0000_0042, 2'b00};
    vecs[1] = '{32'h00,  32'h1122_3344, 4'h3, 2'b00, 6'b000001, 32'h0000_3344, 2'b00};
    vecs[2] = '{32'h00,  32'hAABB_CCDD, 4'hC, 2'b00, 6'b000001, 32'hAABB_3344, 2'b00};
    vecs[3] = '{32'h08,  32'hFFFF_FFFF, 4'h0, 2'b00, 6'b000100, 32'h0000_0000, 2'b00};
    vecs[4] = '{32'h18,  32'h0000_1234, 4'hF, 2'b10, 6'b000000, ST0,           2'b00};
    vecs[5] = '{32'h1C,  32'h0000_5678, 4'hF, 2'b10, 6'b000000, ST1,           2'b00};
    vecs[6] = '{32'h20,  32'h0000_00FF, 4'hF, 2'b10, 6'b000000, 32'h0000_0000, 2'b10};
    vecs[7] = '{32'h0F,  32'h0102_0304, 4'hF, 2'b00, 6'b001000, 32'h0102_0304, 2'b00};
    vecs[8] = '{32'h810, 32'hFFFF_FFFF, 4'hF, 2'b10, 6'b000000, 32'h0000_0000, 2'b10};
    vecs[9] = '{32'h10,  32'h0000_0009, 4'h1, 2'b00, 6'b010000, 32'h0000_0009, 2'b00};

    // Reset values, then ready on the first clock after release.
    repeat (3) step();
    chk("rst_handshake_outs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, '0);
    chk("rst_rdata_pulse", {RDATA, reg_wr_pulse}, '0);
    chk("rst_ctl_reg", ctl_reg, {RST_CTL, 160'h0});
    rst_n = 1'b1;
    step();
    chk("ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

    // W three cycles ahead of AW.
    WDATA = 32'hDEAD_BEEF; WSTRB = 4'h5; WVALID = 1'b1;
    step();
    WVALID = 1'b0;
    chk("w_first_ready", {AWREADY, WREADY, BVALID}, 3'b100);
    step();
    chk("w_first_wait1", {BVALID, reg_wr_pulse}, '0);
    step();
    chk("w_first_wait2", {BVALID, reg_wr_pulse}, '0);
    AWADDR = 32'h04; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("w_first_b", {BVALID, BRESP, reg_wr_pulse}, {1'b1, 2'b00, 6'b000010});
    chk("w_first_reg1", reg_of(1), 32'h00AD_00EF);
    b_done();
    chk("w_first_pulse_once", reg_wr_pulse, 6'b0);

    for (int i = 0; i < 10; i++) begin
      wr_same(vecs[i].addr, vecs[i].data, vecs[i].strb);
      chk($sformatf("v%0d_bvalid", i), BVALID, 1'b1);
      chk($sformatf("v%0d_bresp", i), BRESP, vecs[i].bresp);
      chk($sformatf("v%0d_pulse", i), reg_wr_pulse, vecs[i].pulse);
      b_done();
      chk($sformatf("v%0d_b_clear", i), {BVALID, reg_wr_pulse}, '0);
      rd(vecs[i].addr, d, r);
      chk($sformatf("v%0d_rdata", i), d, vecs[i].rdata);
      chk($sformatf("v%0d_rresp", i), r, vecs[i].rresp);
    end

    // AW ahead of W.
    wait_wr_ready();
    AWADDR = 32'h10; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("aw_first_ready", {AWREADY, WREADY}, 2'b01);
    step();
    WDATA = 32'h7700_0000; WSTRB = 4'h8; WVALID = 1'b1;
    step();
    WVALID = 1'b0;
    chk("aw_first_b", {BVALID, BRESP, reg_wr_pulse}, {1'b1, 2'b00, 6'b010000});
    chk("aw_first_reg4", reg_of(4), 32'h7700_0009);
    b_done();

    // Decode-error read with RREADY held low.
    wait_rd_ready();
    ARADDR = 32'h40; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    chk("rerr_first", {RVALID, RRESP, RDATA, ARREADY}, {1'b1, 2'b10, 32'h0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rerr_hold%0d", i), {RVALID, RRESP, RDATA, ARREADY}, {1'b1, 2'b10, 32'h0, 1'b0});
    end
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    chk("rerr_done", RVALID, 1'b0);
    step();
    chk("rerr_arready_back", ARREADY, 1'b1);

    // B backpressure: a second AW waits for the B handshake.
    wr_same(32'h00, 32'h0000_005A, 4'hF);
    AWADDR = 32'h04; AWVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bhold%0d", i), {BVALID, BRESP, AWREADY, WREADY}, {1'b1, 2'b00, 2'b00});
      step();
    end
    chk("bhold_last", {BVALID, AWREADY, WREADY}, 3'b100);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("bhold_release", {BVALID, AWREADY, WREADY}, 3'b011);
    step();
    AWVALID = 1'b0;
    chk("bhold_aw_taken", {BVALID, AWREADY, WREADY}, 3'b001);
    WDATA = 32'h0000_0066; WSTRB = 4'h1; WVALID = 1'b1;
    step();
    WVALID = 1'b0;
    chk("bhold_second_b", {BVALID, BRESP, reg_wr_pulse}, {1'b1, 2'b00, 6'b000010});
    chk("bhold_regs", {reg_of(1), reg_of(0)}, {32'h00AD_0066, 32'h0000_005A});
    b_done();

    // Read issued in the commit cycle sees the old value; later read sees new.
    wait_wr_ready();
    wait_rd_ready();
    AWADDR = 32'h08; WDATA = 32'h1357_9BDF; WSTRB = 4'hF; ARADDR = 32'h08;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("rw_same_valids", {BVALID, RVALID, reg_wr_pulse}, {2'b11, 6'b000100});
    chk("rw_same_old_data", {RDATA, RRESP}, {32'h0, 2'b00});
    BREADY = 1'b1; RREADY = 1'b1;
    step();
    BREADY = 1'b0; RREADY = 1'b0;
    rd(32'h08, d, r);
    chk("rw_later_new_data", {d, r}, {32'h1357_9BDF, 2'b00});

    // Reset while a write response is pending.
    wr_same(32'h14, 32'h0000_0055, 4'hF);
    chk("rst_mid_pre", {BVALID, reg_of(5)}, {1'b1, 32'h55});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {BVALID, AWREADY, WREADY, ARREADY, reg_wr_pulse}, '0);
    chk("rst_mid_ctl", ctl_reg, {RST_CTL, 160'h0});
    step();
    step();
    rst_n = 1'b1;
    BREADY = 1'b1; RREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst_no_resp%0d", i), {BVALID, RVALID}, 2'b00);
    end
    BREADY = 1'b0; RREADY = 1'b0;
    chk("rst_ready_again", {AWREADY, WREADY, ARREADY}, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
